wb_host_mailbox: RTL and testbench

//  Wishbone slave on the LM32 system bus at slave0 (0x4xxxxxxx).

---
 rtl/wb_host_mailbox_pkg.sv | 20 ++
 rtl/wb_host_mailbox_fifo.sv | 47 ++++
 rtl/wb_host_mailbox.sv | 96 +++++++++
 tb/tb_wb_host_mailbox.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/wb_host_mailbox_pkg.sv
// wb_host_mailbox_pkg: register map, CTRL bit positions and entry layout for the host mailbox.
package wb_host_mailbox_pkg;
    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;
    localparam int ADDR_W       = 13;
    localparam int DATA_W       = 8;
    localparam int ENTRY_W      = ADDR_W + DATA_W;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_FLUSH   = 2;
    localparam int CTRL_OVF_CLR = 3;
    // DATA register image: [31] valid, [20:8] addr, [7:0] data; all zero when nothing is queued
    function automatic logic [31:0] data_word(input logic valid, input logic [ENTRY_W-1:0] e);
        return valid ? {1'b1, 10'b0, e} : 32'b0;
    endfunction
endpackage

// File: rtl/wb_host_mailbox_fifo.sv
// wb_host_mailbox_fifo: RAM-based first-word fall-through FIFO with flush and level.
//  clk, reset        clock, asynchronous active-high reset
//  push, pop, flush  requests; flush overrides push and pop
//  din / dout        tail write data / head data (valid while !empty)
//  full, empty, level occupancy (level is 0..2**DEPTH_LOG2)
module wb_host_mailbox_fifo #(
    parameter int W          = 21,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    logic [W-1:0]        mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                do_push, do_pop;

    // a pop in the same cycle frees the slot, so a push into a full FIFO still succeeds
    assign do_push = push & ~flush & (~full | (pop & ~empty));
    assign do_pop  = pop & ~flush & ~empty;
    assign level   = wr_ptr - rd_ptr;
    assign full    = level[DEPTH_LOG2];
    assign empty   = level == '0;
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(do_push);
            rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
endmodule

// File: rtl/wb_host_mailbox.sv
// wb_host_mailbox: Wishbone slave buffering asynchronous host byte writes as {addr,data} FIFO entries.
//  clk, reset                  system clock, asynchronous active-high reset
//  wb_*                        classic Wishbone slave; wb_adr_i[3:2] selects STATUS/DATA/CTRL/reserved
//  intr                        level interrupt: irq_en & !empty
//  host_addr/data/nwe/ncs      asynchronous host write bus (nwe, ncs active low)
module wb_host_mailbox
    import wb_host_mailbox_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    input  logic               wb_we_i,
    output logic               wb_ack_o,
    output logic               intr,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_data,
    input  logic               host_nwe,
    input  logic               host_ncs
);
    localparam int N = SYNC_STAGES;

    // one stage beyond the synchronizer so the edge compares stage N-1 with N,
    // and the entry is taken from stage N (the last cycle the write was active)
    logic [N:0]              act_p;
    logic [N:0][ADDR_W-1:0]  addr_p;
    logic [N:0][DATA_W-1:0]  data_p;
    logic                    en, irq_en, ovf;
    logic                    req, rd, ctrl_wr, flush, ovf_clr, push, pop, ovf_set;
    logic                    full, empty;
    logic [DEPTH_LOG2:0]     level;
    logic [ENTRY_W-1:0]      head;
    logic [31:0]             status, rd_data;
    reg_sel_e                sel;
    logic                    unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:4]};

    assign sel     = reg_sel_e'(wb_adr_i[3:2]);
    assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign rd      = req & ~wb_we_i;
    assign ctrl_wr = req & wb_we_i & (sel == REG_CTRL);
    assign flush   = ctrl_wr & wb_dat_i[CTRL_FLUSH];
    assign ovf_clr = ctrl_wr & wb_dat_i[CTRL_OVF_CLR];
    assign push    = en & act_p[N] & ~act_p[N-1];
    assign pop     = rd & (sel == REG_DATA) & ~empty;
    assign ovf_set = push & ~flush & full & ~pop;
    assign intr    = irq_en & ~empty;
    assign status  = {16'b0, 8'(level), 5'b0, ovf, full, ~empty};
    assign rd_data = sel == REG_STATUS ? status :
                     sel == REG_DATA   ? data_word(~empty, head) :
                     sel == REG_CTRL   ? {30'b0, irq_en, en} : 32'b0;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            act_p    <= '0;
            addr_p   <= '0;
            data_p   <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            act_p    <= {act_p[N-1:0], ~host_nwe & ~host_ncs};
            addr_p   <= {addr_p[N-1:0], host_addr};
            data_p   <= {data_p[N-1:0], host_data};
            wb_ack_o <= req;
            wb_dat_o <= rd ? rd_data : '0;
            if (ctrl_wr) begin
                en     <= wb_dat_i[CTRL_EN];
                irq_en <= wb_dat_i[CTRL_IRQ_EN];
            end
            ovf      <= (ovf & ~ovf_clr) | ovf_set;
        end

    wb_host_mailbox_fifo #(.W(ENTRY_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({addr_p[N], data_p[N]}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule

// File: tb/tb_wb_host_mailbox.sv
// tb_wb_host_mailbox: directed self-checking bench for the host mailbox.
module tb_wb_host_mailbox;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o, intr;
    logic [12:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        host_nwe = 1'b1, host_ncs = 1'b1;
    int          checks = 0, errors = 0;
    logic [31:0] rdat;

    localparam logic [31:0] A_STATUS = 32'h4000_0000, A_DATA = 32'h4000_0004,
                            A_CTRL = 32'h4000_0008, A_RSVD = 32'h4000_000C;

    always #5 clk = ~clk;

    wb_host_mailbox dut (
        .clk(clk), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .intr(intr), .host_addr(host_addr), .host_data(host_data),
        .host_nwe(host_nwe), .host_ncs(host_ncs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // all bus tasks start and end just after a falling clock edge
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             output logic [31:0] dat);
        int n = 0;
        wb_adr_i = adr; wb_dat_i = wdat; wb_we_i = we; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) begin
            checks++;
            errors++;
            $error("FAIL ack_timeout observed 0 expected 1 at adr %h", adr);
        end
        dat = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        wb_access(1'b0, adr, 32'h0, dat);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] d;
        wb_access(1'b1, adr, wdat, d);
    endtask

    task automatic host_start(input logic [12:0] a, input logic [7:0] d);
        host_addr = a; host_data = d; host_ncs = 1'b0; host_nwe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic host_write(input logic [12:0] a, input logic [7:0] d);
        host_start(a, d);
        host_nwe = 1'b1; host_ncs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb_ack_o), 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_intr", 32'(intr), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        wb_read(A_STATUS, rdat); check("rst_status", rdat, 32'h0);
        wb_read(A_CTRL, rdat);   check("rst_ctrl", rdat, 32'h0);
        wb_write(A_RSVD, 32'hFFFF_FFFF);
        wb_read(A_RSVD, rdat);   check("rsvd_read", rdat, 32'h0);

        // single write round trip
        wb_write(A_CTRL, 32'h1);
        host_write(13'h0123, 8'hA5);
        wb_read(A_STATUS, rdat); check("t1_status", rdat, 32'h0000_0101);
        wb_write(A_DATA, 32'h0);
        wb_read(A_DATA, rdat);   check("t1_data", rdat, 32'h8001_23A5);
        wb_read(A_STATUS, rdat); check("t1_status_after", rdat, 32'h0);
        wb_read(A_DATA, rdat);   check("t1_empty_data", rdat, 32'h0);

        // 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) host_write(13'(i), 8'(8'h10 + i));
        wb_read(A_STATUS, rdat); check("t2_status_full", rdat, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            wb_read(A_DATA, rdat);
            check($sformatf("t2_data%0d", i), rdat, 32'h8000_0000 | (i << 8) | (32'h10 + i));
        end
        wb_read(A_STATUS, rdat); check("t2_status_ovf", rdat, 32'h0000_0004);
        wb_write(A_CTRL, 32'h9);
        wb_read(A_STATUS, rdat); check("t2_ovf_clear", rdat, 32'h0);
        wb_read(A_CTRL, rdat);   check("t2_ctrl", rdat, 32'h1);

        // disabled capture, then interrupt
        wb_write(A_CTRL, 32'h0);
        host_write(13'h0055, 8'h66);
        wb_read(A_STATUS, rdat); check("t3_disabled", rdat, 32'h0);
        wb_write(A_CTRL, 32'h3);
        check("t3_intr_idle", 32'(intr), 32'h0);
        host_write(13'h1ABC, 8'h3C);
        check("t3_intr_set", 32'(intr), 32'h1);
        wb_read(A_DATA, rdat);   check("t3_data", rdat, 32'h801A_BC3C);
        check("t3_intr_clear", 32'(intr), 32'h0);

        // pop coinciding with a push while full
        wb_write(A_CTRL, 32'h1);
        for (int i = 0; i < 16; i++) host_write(13'(13'h100 + i), 8'(i));
        wb_read(A_STATUS, rdat); check("t4_full", rdat, 32'h0000_1003);
        host_start(13'h1FFF, 8'hEE);
        host_nwe = 1'b1; host_ncs = 1'b1;
        repeat (2) @(negedge clk);
        wb_read(A_DATA, rdat);   check("t4_pop_push", rdat, 32'h8001_0000);
        repeat (4) @(negedge clk);
        wb_read(A_STATUS, rdat); check("t4_level", rdat, 32'h0000_1003);
        for (int i = 1; i < 16; i++) begin
            wb_read(A_DATA, rdat);
            check($sformatf("t4_data%0d", i), rdat, 32'h8001_0000 | (i << 8) | i);
        end
        wb_read(A_DATA, rdat);   check("t4_last", rdat, 32'h801F_FFEE);
        wb_read(A_STATUS, rdat); check("t4_empty", rdat, 32'h0);

        // flush on the same cycle as a push
        wb_write(A_CTRL, 32'h3);
        for (int i = 0; i < 5; i++) host_write(13'(13'h40 + i), 8'(8'h80 + i));
        wb_read(A_STATUS, rdat); check("t5_five", rdat, 32'h0000_0501);
        check("t5_intr", 32'(intr), 32'h1);
        host_start(13'h0777, 8'h77);
        host_nwe = 1'b1; host_ncs = 1'b1;
        repeat (2) @(negedge clk);
        wb_write(A_CTRL, 32'h7);
        repeat (4) @(negedge clk);
        wb_read(A_STATUS, rdat); check("t5_flushed", rdat, 32'h0);
        wb_read(A_CTRL, rdat);   check("t5_ctrl", rdat, 32'h3);
        check("t5_intr_clear", 32'(intr), 32'h0);

        // reset in the middle of a host write
        for (int i = 0; i < 3; i++) host_write(13'(i), 8'(i));
        wb_read(A_STATUS, rdat); check("t6_three", rdat, 32'h0000_0301);
        host_addr = 13'h0ABC; host_data = 8'h99; host_ncs = 1'b0; host_nwe = 1'b0;
        repeat (2) @(negedge clk);
        wb_adr_i = A_STATUS; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_ack", 32'(wb_ack_o), 32'h0);
        check("t6_rst_dat", wb_dat_o, 32'h0);
        check("t6_rst_intr", 32'(intr), 32'h0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        host_nwe = 1'b1; host_ncs = 1'b1;
        repeat (6) @(negedge clk);
        wb_read(A_STATUS, rdat); check("t6_status", rdat, 32'h0);
        wb_read(A_CTRL, rdat);   check("t6_ctrl", rdat, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
